uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver and successor to the fixed 8N2 receiver. It adds:
- input synchronisation
- mid-bit sampling with start-bit validation
- configurable data width, parity and stop bits
- framing, parity and overrun detection
- a valid/ready output handshake

It sits between the rx pin and the byte-consuming logic (FIFO or command decoder).

Parameters:
CLKS_PER_BIT, 104, Clk cycles per bit period (>=4).
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 2, stop bits checked, legal 1 or 2.

Ports:
Clk  in  1  system clock, all logic on rising edge.
Rst_n  in  1  asynchronous active-low reset.
rx  in  1  serial line, idle high, asynchronous to Clk.
data  out  DATA_BITS  received word.
data_valid  out  1  data and error flags valid; held until accepted.
data_ready  in  1  consumer accepts when data_valid && data_ready.
parity_err  out  1  parity mismatch for the current word; qualified by data_valid; 0 when PARITY = 0.
frame_err  out  1  a stop bit sampled 0; qualified by data_valid.
overrun  out  1  one-cycle pulse: a frame completed while data_valid was high and not accepted.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, Rst_n low): all outputs 0 and state = IDLE. Counters, bit index, shift register and synchroniser flops clear; synchroniser flops clear to 1. Reset mid-frame aborts the frame with no output.
- Synchroniser: 2-flop chain, rx_s = rx delayed 2 cycles; all decisions use rx_s.
- Counter: cnt, width $clog2(CLKS_PER_BIT).
- State machine:
  - IDLE: cnt = 0. If rx_s == 0, go to START.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division), then sample. Sample 0: cnt = 0, bit index = 0, go to DATA. Sample 1: false start, return to IDLE, no flags.
  - DATA: sample when cnt == CLKS_PER_BIT-1, then cnt = 0. Shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. Error when (XOR of data bits ^ sample) != (PARITY == 2).
  - STOP: STOP_BITS samples at bit-period spacing; any 0 sets the frame error. After the last sample, go to DONE.
  - DONE (1 cycle): commit the word.
    - data_valid low, or high and accepted this same cycle: load data, parity_err and frame_err; data_valid = 1.
    - data_valid high and not accepted: keep the old word and flags, pulse overrun, drop the new frame.
    - Then go to IDLE if rx_s == 1, else BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. This prevents a held-low line (break) from retriggering START.
- Handshake:
  - data_valid falls the cycle after data_valid && data_ready, unless DONE reloads it in that same cycle.
  - Flags stay stable while data_valid is high.
- Latency: data_valid rises 2 (sync) + 1 (DONE) cycles after the mid-point of the last stop bit.
- Sampling points relative to the synchronised falling edge: bit k (start = 0) sampled at CLKS_PER_BIT/2 + k*CLKS_PER_BIT cycles.
- Widths: the bit index is wide enough for DATA_BITS + 2. Parity is computed over DATA_BITS only.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE, BREAK)
  - PARITY encodings PAR_NONE/PAR_EVEN/PAR_ODD
- Sub-module uart_sync2: 2-flop synchroniser, reset value 1. It is reused by the future TX/loopback blocks.

Test Plan:
(Bench uses CLKS_PER_BIT = 16 unless stated.)
- 8N1, send 0xA5, data_ready held 1 -> data = 0xA5, data_valid pulses 1 cycle, parity_err = 0, frame_err = 0.
- 8E2 (PARITY = 1, STOP_BITS = 2), send 0x03 with parity bit 1 -> parity_err = 1, data = 0x03. Same word with parity 0 -> parity_err = 0.
- Glitch: rx low for 5 cycles only -> no data_valid, busy returns to 0, state = IDLE.
- Framing/break: 0x00 with stop = 0, line held low 100 cycles -> frame_err = 1, data = 0x00, no second frame until rx returns high.
- Overrun: data_ready = 0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses once. Assert data_ready -> data_valid drops next cycle.
- Reset mid-frame: Rst_n low during DATA bit 3 -> outputs 0 immediately. Next full frame 0x5A after reset is received correctly. DATA_BITS = 7 variant sends 0x7F -> data = 0x7F.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ==== uart_pkg -- shared UART receiver state encoding and parity modes (rev 1.0) ====
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5,
      S_BREAK  = 3'd6
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ==== uart_sync2 -- two-flop synchroniser, resets to line-idle 1 (rev 1.0) ====
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ==== uart_rx_param -- parametrised UART receiver with valid/ready output (rev 1.0) ====
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS + 3);
   localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic             ODD_REF   = 1'(PARITY == PAR_ODD);

   logic rx_s;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_pend_q, perr_pend_d;
   logic                 ferr_pend_q, ferr_pend_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 bit_tick;

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   assign bit_tick = (cnt_q == BIT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      perr_pend_d = perr_pend_q;
      ferr_pend_d = ferr_pend_q;
      data_d      = data_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      ovr_d       = 1'b0;
      valid_d     = valid_q && !data_ready;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d       = '0;
               idx_d       = '0;
               perr_pend_d = 1'b0;
               ferr_pend_d = 1'b0;
               state_d     = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               cnt_d       = '0;
               perr_pend_d = ((^shift_q) ^ rx_s) != ODD_REF;
               state_d     = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_tick) begin
               cnt_d = '0;
               if (!rx_s) ferr_pend_d = 1'b1;
               if (idx_q == STOP_LAST) state_d = S_DONE;
               else                    idx_d   = idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // A word still awaiting acceptance wins; the new frame is dropped.
            if (!valid_q || data_ready) begin
               data_d  = shift_q;
               perr_d  = perr_pend_q;
               ferr_d  = ferr_pend_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
            state_d = rx_s ? S_IDLE : S_BREAK;
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         perr_pend_q <= 1'b0;
         ferr_pend_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         perr_pend_q <= perr_pend_d;
         ferr_pend_q <= ferr_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         ovr_q       <= ovr_d;
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
